// File: rtl/distance_filter.sv
// rtl/distance_filter.sv - 4-tap moving-average distance filter with hysteretic obstacle flag
//
// Samples distance_in once per frame. It keeps a 4-sample window, registers the window
// sum, then registers the truncated average. A debounced FILL/CLEAR/BLOCKED state
// machine drives the obstacle flag.
//
// Optional feature macro: DIST_FILT_SPIKE_REJECT_EN (spike rejection of outlier samples).
//
// Ports:
//   clk_50M      in   1   50 MHz clock
//   reset        in   1   synchronous, active-low reset
//   distance_in  in   16  distance in mm from ranging block, stable between updates
//   avg_mm       out  16  moving average of the last 4 accepted samples, mm
//   avg_valid    out  1   one-cycle pulse when avg_mm updates
//   obstacle     out  1   debounced obstacle flag
//   spike_flag   out  1   one-cycle pulse on a rejected sample (0 without the macro)

module distance_filter #(
    parameter int FRAME_CYCLES = 600553,
    parameter int NEAR_MM      = 70,
    parameter int FAR_MM       = 90,
    parameter int CONFIRM      = 3,
    parameter int SPIKE_MM     = 200
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic [15:0] distance_in,
    output logic [15:0] avg_mm,
    output logic        avg_valid,
    output logic        obstacle,
    output logic        spike_flag
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [15:0] NEAR_T = 16'(NEAR_MM);
    localparam logic [15:0] FAR_T = 16'(FAR_MM);
    localparam logic [3:0] CONFIRM_M1 = 4'(CONFIRM - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CLEAR   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  frame_cnt;
    logic [15:0]       w0, w1, w2, w3;
    logic [17:0]       sum;
    logic [1:0]        fill_cnt;
    logic [3:0]        cnt;
    logic              s1_valid;
    logic              s2_valid;
    logic              tick;
    logic              accept;

    assign tick = (frame_cnt == FRAME_LAST);

`ifdef DIST_FILT_SPIKE_REJECT_EN
    localparam logic [15:0] SPIKE_T = 16'(SPIKE_MM);

    logic [1:0]  rej_cnt;
    logic [15:0] diff;
    logic        is_spike;
    logic        reject;

    always_comb begin
        diff = (distance_in >= avg_mm) ? (distance_in - avg_mm) : (avg_mm - distance_in);
        // Three rejects in a row let the next sample through so a genuine step is tracked.
        is_spike = (state != FILL) && (diff > SPIKE_T) && (rej_cnt != 2'd3);
        accept   = tick && !is_spike;
        reject   = tick && is_spike;
    end

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            rej_cnt    <= 2'd0;
            spike_flag <= 1'b0;
        end else begin
            spike_flag <= reject;
            if (reject) begin
                rej_cnt <= rej_cnt + 2'd1;
            end else if (accept) begin
                rej_cnt <= 2'd0;
            end
        end
    end
`else
    assign accept     = tick;
    assign spike_flag = 1'b0;
`endif

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            state     <= FILL;
            frame_cnt <= '0;
            w0        <= 16'd0;
            w1        <= 16'd0;
            w2        <= 16'd0;
            w3        <= 16'd0;
            sum       <= 18'd0;
            fill_cnt  <= 2'd0;
            cnt       <= 4'd0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            avg_mm    <= 16'd0;
            avg_valid <= 1'b0;
            obstacle  <= 1'b0;
        end else begin
            frame_cnt <= tick ? '0 : frame_cnt + 1'b1;

            if (accept) begin
                w0 <= distance_in;
                w1 <= w0;
                w2 <= w1;
                w3 <= w2;
            end

            // Sum and average stages run every cycle; only the valid bits gate updates.
            sum       <= {2'b00, w0} + {2'b00, w1} + {2'b00, w2} + {2'b00, w3};
            s2_valid  <= s1_valid;
            avg_valid <= s2_valid;
            if (s2_valid) begin
                avg_mm <= sum[17:2];
            end

            s1_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (fill_cnt == 2'd3) begin
                            // Window now full: this sample starts the first average.
                            s1_valid <= 1'b1;
                            fill_cnt <= 2'd0;
                            cnt      <= 4'd0;
                            state    <= CLEAR;
                        end else begin
                            fill_cnt <= fill_cnt + 2'd1;
                        end
                    end
                end
                CLEAR: begin
                    s1_valid <= accept;
                    if (avg_valid) begin
                        if (avg_mm < NEAR_T) begin
                            if (cnt == CONFIRM_M1) begin
                                cnt      <= 4'd0;
                                obstacle <= 1'b1;
                                state    <= BLOCKED;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                end
                BLOCKED: begin
                    s1_valid <= accept;
                    if (avg_valid) begin
                        if (avg_mm > FAR_T) begin
                            if (cnt == CONFIRM_M1) begin
                                cnt      <= 4'd0;
                                obstacle <= 1'b0;
                                state    <= CLEAR;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    state    <= FILL;
                    fill_cnt <= 2'd0;
                    cnt      <= 4'd0;
                    obstacle <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// tb/tb_distance_filter.sv - directed self-checking bench for distance_filter

module tb_distance_filter;

    logic        clk_50M;
    logic        reset;
    logic [15:0] distance_in;
    logic [15:0] avg_mm;
    logic        avg_valid;
    logic        obstacle;
    logic        spike_flag;

    int n_vec;
    int n_fail;

    distance_filter #(
        .FRAME_CYCLES(16),
        .NEAR_MM(70),
        .FAR_MM(90),
        .CONFIRM(2),
        .SPIKE_MM(200)
    ) dut (
        .clk_50M(clk_50M),
        .reset(reset),
        .distance_in(distance_in),
        .avg_mm(avg_mm),
        .avg_valid(avg_valid),
        .obstacle(obstacle),
        .spike_flag(spike_flag)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    task automatic cyc();
        @(posedge clk_50M);
        @(negedge clk_50M);
    endtask

    // Waits (bounded) for the next avg_valid pulse; a timeout counts as a miscompare.
    task automatic wait_avg(input string name, output logic [15:0] v);
        bit ok;
        ok = 0;
        v  = 16'hxxxx;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (avg_valid === 1'b1) begin
                ok = 1;
                v  = avg_mm;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: avg_valid seen=0 required=1 within 40 cycles", name);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_vec++;
        if (avg_mm !== 16'd0 || avg_valid !== 1'b0 || obstacle !== 1'b0 || spike_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: avg_mm=%0d avg_valid=%b obstacle=%b spike_flag=%b required all 0",
                     name, avg_mm, avg_valid, obstacle, spike_flag);
        end
    endtask

    // Asserts reset for two edges and releases it at a negedge; the next posedge is frame edge 1.
    task automatic do_reset(input string name);
        @(negedge clk_50M);
        reset = 1'b0;
        @(posedge clk_50M);
        @(posedge clk_50M);
        @(negedge clk_50M);
        check_outputs_zero(name);
        reset = 1'b1;
    endtask

    // From reset release: ticks accepted at edges 16,32,48,64, first avg_valid after edge 66.
    task automatic check_fill(input string name, input logic [15:0] value);
        bit early;
        early = 0;
        for (int i = 1; i <= 65; i++) begin
            cyc();
            if (avg_valid !== 1'b0) early = 1;
        end
        n_vec++;
        if (early) begin
            n_fail++;
            $display("FAIL %s_early: avg_valid seen=1 required=0 before 4th sample", name);
        end
        cyc();
        n_vec++;
        if (avg_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: avg_valid=%b required=1 at edge 66", name, avg_valid);
        end
        n_vec++;
        if (avg_mm !== value) begin
            n_fail++;
            $display("FAIL %s_avg: avg_mm=%0d required=%0d", name, avg_mm, value);
        end
        n_vec++;
        if (obstacle !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_obst: obstacle=%b required=0", name, obstacle);
        end
        cyc();
        n_vec++;
        if (avg_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: avg_valid=%b required=0 one cycle later", name, avg_valid);
        end
    endtask

    task automatic test_reset();
        distance_in = 16'd100;
        do_reset("reset_state");
    endtask

    task automatic test_fill_latency();
        check_fill("fill", 16'd100);
    endtask

    task automatic test_truncation();
        distance_in = 16'd100;
        do_reset("trunc_reset");
        repeat (16) @(posedge clk_50M);
        @(negedge clk_50M);
        distance_in = 16'd101;
        repeat (16) @(posedge clk_50M);
        @(negedge clk_50M);
        distance_in = 16'd102;
        repeat (16) @(posedge clk_50M);
        @(negedge clk_50M);
        distance_in = 16'd104;
        repeat (18) @(posedge clk_50M);
        @(negedge clk_50M);
        n_vec++;
        if (avg_valid !== 1'b1 || avg_mm !== 16'd101) begin
            n_fail++;
            $display("FAIL trunc: avg_valid=%b avg_mm=%0d required valid=1 avg=101", avg_valid, avg_mm);
        end
    endtask

    task automatic test_assert();
        logic [15:0] exp_avg [4];
        logic [15:0] v;
        exp_avg = '{16'd85, 16'd70, 16'd55, 16'd40};
        distance_in = 16'd100;
        do_reset("assert_reset");
        check_fill("assert_fill", 16'd100);
        distance_in = 16'd40;
        for (int k = 0; k < 4; k++) begin
            wait_avg($sformatf("assert_wait%0d", k), v);
            n_vec++;
            if (v !== exp_avg[k]) begin
                n_fail++;
                $display("FAIL assert_avg%0d: avg_mm=%0d required=%0d", k, v, exp_avg[k]);
            end
            n_vec++;
            if (obstacle !== 1'b0) begin
                n_fail++;
                $display("FAIL assert_obst%0d: obstacle=%b required=0", k, obstacle);
            end
        end
        cyc();
        n_vec++;
        if (obstacle !== 1'b1) begin
            n_fail++;
            $display("FAIL assert_set: obstacle=%b required=1 after avg 40", obstacle);
        end
    endtask

    task automatic test_clear();
        logic [15:0] exp_avg [5];
        logic [15:0] v;
        exp_avg = '{16'd53, 16'd67, 16'd81, 16'd95, 16'd95};
        distance_in = 16'd95;
        for (int k = 0; k < 5; k++) begin
            wait_avg($sformatf("clear_wait%0d", k), v);
            n_vec++;
            if (v !== exp_avg[k]) begin
                n_fail++;
                $display("FAIL clear_avg%0d: avg_mm=%0d required=%0d", k, v, exp_avg[k]);
            end
            if (k == 3) begin
                cyc();
                n_vec++;
                if (obstacle !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clear_hold: obstacle=%b required=1 after first 95", obstacle);
                end
            end
        end
        cyc();
        n_vec++;
        if (obstacle !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_drop: obstacle=%b required=0 after second 95", obstacle);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] exp_avg [3];
        logic [15:0] v;
        exp_avg = '{16'd81, 16'd67, 16'd53};
        distance_in = 16'd40;
        for (int k = 0; k < 3; k++) begin
            wait_avg($sformatf("mid_wait%0d", k), v);
            n_vec++;
            if (v !== exp_avg[k]) begin
                n_fail++;
                $display("FAIL mid_avg%0d: avg_mm=%0d required=%0d", k, v, exp_avg[k]);
            end
        end
        cyc();
        n_vec++;
        if (obstacle !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_obst: obstacle=%b required=1 before reset", obstacle);
        end
        reset = 1'b0;
        cyc();
        check_outputs_zero("mid_reset");
        distance_in = 16'd100;
        reset = 1'b1;
        check_fill("mid_refill", 16'd100);
    endtask

    task automatic test_spike();
        int spikes;
        int avgs;
        logic [15:0] v;
        logic [15:0] last_avg;
`ifdef DIST_FILT_SPIKE_REJECT_EN
        distance_in = 16'd600;
        spikes = 0;
        avgs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (spike_flag === 1'b1) spikes++;
            if (avg_valid === 1'b1) avgs++;
        end
        n_vec++;
        if (spikes != 1 || avgs != 0) begin
            n_fail++;
            $display("FAIL spike_single: spikes=%0d avg_valids=%0d required 1 and 0", spikes, avgs);
        end
        n_vec++;
        if (avg_mm !== 16'd100) begin
            n_fail++;
            $display("FAIL spike_hold: avg_mm=%0d required=100", avg_mm);
        end
        distance_in = 16'd100;
        wait_avg("spike_recover_wait", v);
        n_vec++;
        if (v !== 16'd100) begin
            n_fail++;
            $display("FAIL spike_recover: avg_mm=%0d required=100", v);
        end
        distance_in = 16'd600;
        spikes = 0;
        avgs = 0;
        last_avg = 16'd0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (spike_flag === 1'b1) spikes++;
            if (avg_valid === 1'b1) begin
                avgs++;
                last_avg = avg_mm;
                break;
            end
        end
        n_vec++;
        if (spikes != 3 || avgs != 1) begin
            n_fail++;
            $display("FAIL spike_step: spikes=%0d avg_valids=%0d required 3 and 1", spikes, avgs);
        end
        n_vec++;
        if (last_avg !== 16'd225) begin
            n_fail++;
            $display("FAIL spike_accept: avg_mm=%0d required=225", last_avg);
        end
`else
        distance_in = 16'd600;
        spikes = 0;
        avgs = 0;
        last_avg = 16'd0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (spike_flag !== 1'b0) spikes++;
            if (avg_valid === 1'b1) begin
                avgs++;
                last_avg = avg_mm;
            end
        end
        v = last_avg;
        n_vec++;
        if (spikes != 0 || avgs != 1) begin
            n_fail++;
            $display("FAIL nospike_flags: spikes=%0d avg_valids=%0d required 0 and 1", spikes, avgs);
        end
        n_vec++;
        if (v !== 16'd225) begin
            n_fail++;
            $display("FAIL nospike_avg: avg_mm=%0d required=225", v);
        end
`endif
    endtask

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        distance_in = 16'd0;
        test_reset();
        test_fill_latency();
        test_truncation();
        test_assert();
        test_clear();
        test_reset_midframe();
        test_spike();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
